iiitb_piso_stream: RTL and testbench

Parametrised parallel-in/serial-out serialiser with a valid/ready load port, a shift-enable stall input and frame markers. It is the next-generation PISO for the iiitb serial datapath. It generalises the fixed 4-bit shifter to any width and either bit order, and it supports zero-gap back-to-back frames. Vacated register bits fill with a defined level, never X.

---
 rtl/iiitb_piso_stream_pkg.sv | 15 +
 rtl/iiitb_piso_stream_if.sv | 25 ++
 rtl/iiitb_piso_stream_bitcnt.sv | 26 ++
 rtl/iiitb_piso_stream.sv | 110 +++++++++++
 tb/tb_iiitb_piso_stream.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/iiitb_piso_stream_pkg.sv
// Shared types and helpers for the iiitb PISO serialiser.
package iiitb_piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } piso_state_e;

    // Bits needed to count down from WIDTH-1 to 0; never narrower than 1.
    function automatic int piso_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/iiitb_piso_stream_if.sv
// Load / serial-output bundle of the iiitb PISO serialiser.
// master = upstream producer and downstream consumer side, slave = serialiser.
interface iiitb_piso_stream_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output load_valid, data_in, shift_en,
        input  load_ready, sout, sout_valid, frame_start, frame_done, busy
    );

    modport slave (
        input  load_valid, data_in, shift_en,
        output load_ready, sout, sout_valid, frame_start, frame_done, busy
    );
endinterface

// File: rtl/iiitb_piso_stream_bitcnt.sv
// Loadable down-counter with a zero flag; it saturates at zero instead of wrapping.
module iiitb_piso_bitcnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    // Load wins over decrement; decrement is ignored once the count is zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/iiitb_piso_stream.sv
// Parametrised parallel-in/serial-out serialiser with frame markers.
// Optional feature macro: IIITB_PISO_PARITY_EN appends an even-parity bit to each frame.
module iiitb_piso_stream
    import iiitb_piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    iiitb_piso_stream_if.slave bus
);

    localparam int CW = piso_cnt_width(WIDTH);
    localparam logic [1:0]    S_IDLE  = ST_IDLE;
    localparam logic [1:0]    S_SHIFT = ST_SHIFT;
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             in_shift;
    logic             out_bit;
    logic             frame_end_edge;
    logic             accept;

    assign in_shift = (state == S_SHIFT);

    // Output end of the register and the one-place shift toward it.
    assign out_bit    = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
    assign shreg_next = LSB_FIRST ? {IDLE_LEVEL, shreg[WIDTH-1:1]}
                                  : {shreg[WIDTH-2:0], IDLE_LEVEL};

`ifdef IIITB_PISO_PARITY_EN
    localparam logic [1:0] S_PAR = ST_PAR;
    logic in_par;
    logic par;

    assign in_par = (state == S_PAR);
    // The last bit of a frame is the parity bit.
    assign frame_end_edge = in_par && bus.shift_en;

    // Even parity captured alongside the word so it never depends on data_in later.
    always_ff @(posedge clk) begin
        if (!rst_n)
            par <= 1'b0;
        else if (accept)
            par <= ^bus.data_in;
    end
`else
    // The last bit of a frame is the final data bit.
    assign frame_end_edge = in_shift && cnt_zero && bus.shift_en;
`endif

    // A new word can enter when idle, or on the very edge that consumes the last bit.
    assign bus.load_ready = rst_n && ((state == S_IDLE) || frame_end_edge);
    assign accept         = bus.load_valid && bus.load_ready;

    iiitb_piso_bitcnt #(.CW(CW)) u_bitcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .dec      (in_shift && bus.shift_en),
        .load_val (CNT_TOP),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // State and shift register: reload takes priority, otherwise advance on shift_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            shreg <= {WIDTH{IDLE_LEVEL}};
        end else if (accept) begin
            state <= S_SHIFT;
            shreg <= bus.data_in;
        end else if (bus.shift_en) begin
            if (in_shift) begin
                shreg <= shreg_next;
`ifdef IIITB_PISO_PARITY_EN
                if (cnt_zero) state <= S_PAR;
`else
                if (cnt_zero) state <= S_IDLE;
`endif
            end
`ifdef IIITB_PISO_PARITY_EN
            else if (in_par) begin
                state <= S_IDLE;
            end
`endif
        end
    end

    // Outputs are pure decodes of registered state.
`ifdef IIITB_PISO_PARITY_EN
    assign bus.sout       = in_shift ? out_bit : (in_par ? par : IDLE_LEVEL);
    assign bus.sout_valid = in_shift || in_par;
    assign bus.frame_done = in_par;
`else
    assign bus.sout       = in_shift ? out_bit : IDLE_LEVEL;
    assign bus.sout_valid = in_shift;
    assign bus.frame_done = in_shift && cnt_zero;
`endif
    assign bus.frame_start = in_shift && (cnt == CNT_TOP);
    assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_iiitb_piso_stream.sv
// Bench for iiitb_piso_stream: two instances (LSB-first/idle 0 and MSB-first/idle 1)
// share stimulus and are compared each cycle against a frame-position model.
// Honours IIITB_PISO_PARITY_EN like the design.
module tb_iiitb_piso_stream;

    localparam int W = 8;
`ifdef IIITB_PISO_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif
    localparam logic IDL0 = 1'b0;
    localparam logic IDL1 = 1'b1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lv = 1'b0;
    logic         se = 1'b0;
    logic [W-1:0] din = '0;

    always #5 clk = ~clk;

    iiitb_piso_stream_if #(.WIDTH(W)) bus0 ();
    iiitb_piso_stream_if #(.WIDTH(W)) bus1 ();

    assign bus0.load_valid = lv;
    assign bus0.data_in    = din;
    assign bus0.shift_en   = se;
    assign bus1.load_valid = lv;
    assign bus1.data_in    = din;
    assign bus1.shift_en   = se;

    iiitb_piso_stream #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(IDL0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    iiitb_piso_stream #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(IDL1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    // Model: each instance holds its current frame in transmit order plus the
    // number of frame bits not yet consumed.
    logic [W:0] fb [2];
    int         rem [2];
    bit         acc_last;

    function automatic logic [W:0] mk_frame(input logic [W-1:0] d, input bit lsb);
        logic [W:0] f;
        for (int k = 0; k < W; k++) f[k] = lsb ? d[k] : d[W-1-k];
        f[W] = ^d;
        return f;
    endfunction

    function automatic bit exp_ready(input int r);
        return rst_n && ((r == 0) || (se && (r == 1)));
    endfunction

    always @(posedge clk) begin
        bit acc;
        acc = lv && exp_ready(rem[0]);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                rem[i] = 0;
            end else begin
                if (se && rem[i] > 0) rem[i] = rem[i] - 1;
                if (acc) begin
                    rem[i] = FLEN;
                    fb[i]  = mk_frame(din, (i == 0));
                end
            end
        end
        acc_last = rst_n && acc;
    end

    initial begin
        rem[0] = 0; rem[1] = 0; fb[0] = '0; fb[1] = '0; acc_last = 1'b0;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [63:0] cap0, cap1;
    int ncap, start_c, done_c, drop_c, nrdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp(input int i, input logic so, input logic sv, input logic fs,
                       input logic fd, input logic lr, input logic bz);
        logic e_so;
        int   r;
        r    = rem[i];
        e_so = (i == 0) ? IDL0 : IDL1;
        if (r > 0) e_so = fb[i][FLEN - r];
        chk($sformatf("u%0d.sout", i),        32'(so), 32'(e_so));
        chk($sformatf("u%0d.sout_valid", i),  32'(sv), 32'(r > 0));
        chk($sformatf("u%0d.frame_start", i), 32'(fs), 32'(r == FLEN));
        chk($sformatf("u%0d.frame_done", i),  32'(fd), 32'(r == 1));
        chk($sformatf("u%0d.load_ready", i),  32'(lr), 32'(exp_ready(r)));
        chk($sformatf("u%0d.busy", i),        32'(bz), 32'(r > 0));
    endtask

    task automatic clear();
        cap0 = '0; cap1 = '0; ncap = 0; start_c = -1; done_c = -1; drop_c = -1; nrdy = 0;
    endtask

    // One clock: compare and record at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        cmp(0, bus0.sout, bus0.sout_valid, bus0.frame_start, bus0.frame_done,
            bus0.load_ready, bus0.busy);
        cmp(1, bus1.sout, bus1.sout_valid, bus1.frame_start, bus1.frame_done,
            bus1.load_ready, bus1.busy);
        if (bus0.sout_valid && se && ncap < 64) begin
            cap0[ncap] = bus0.sout;
            cap1[ncap] = bus1.sout;
            ncap++;
        end
        if (bus0.frame_start && start_c < 0) start_c = cyc;
        if (bus0.frame_done && se) done_c = cyc;
        if (start_c >= 0 && drop_c < 0 && !bus0.busy) drop_c = cyc;
        if (lv && bus0.load_ready) nrdy++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_one(input logic [W-1:0] d);
        lv = 1'b1; din = d; se = 1'b1;
        tick();
        lv = 1'b0;
    endtask

    initial begin
        clear();
        repeat (3) tick();
        chk("rst.sout0", 32'(bus0.sout), 32'(IDL0));
        chk("rst.sout1", 32'(bus1.sout), 32'(IDL1));
        chk("rst.valid", 32'(bus0.sout_valid), 0);
        chk("rst.ready", 32'(bus0.load_ready), 0);
        chk("rst.busy",  32'(bus1.busy), 0);
        rst_n = 1'b1;
        tick();

        // Single frame 8'h1E
        clear();
        load_one(8'h1E);
        repeat (FLEN + 3) tick();
        chk("t1.nbits", ncap, FLEN);
        chk("t1.lsb", 32'(cap0[7:0]), 32'h1E);
        chk("t1.msb", 32'(cap1[7:0]), 32'h78);
        chk("t1.start_to_done", done_c - start_c, FLEN - 1);
        chk("t1.busy_drop", drop_c - done_c, 1);

        // Back-to-back FF then 00, load_valid held
        clear();
        lv = 1'b1; din = 8'hFF; se = 1'b1;
        tick();
        din = 8'h00;
        repeat (FLEN) tick();
        lv = 1'b0;
        repeat (FLEN + 3) tick();
        chk("t2.nbits", ncap, 2 * FLEN);
        chk("t2.first", 32'(cap0[7:0]), 32'hFF);
        chk("t2.second", 32'(cap0[FLEN +: 8]), 32'h00);
        chk("t2.contig", done_c - start_c, 2 * FLEN - 1);
        chk("t2.ready_cycles", nrdy, 2);

        // Stall for 3 cycles while the second bit of 8'hA5 is on sout
        clear();
        load_one(8'hA5);
        tick();
        se = 1'b0;
        tick();
        chk("t3.stall_sout", 32'(bus0.sout), 0);
        chk("t3.stall_valid", 32'(bus0.sout_valid), 1);
        repeat (2) tick();
        se = 1'b1;
        repeat (FLEN + 3) tick();
        chk("t3.data", 32'(cap0[7:0]), 32'hA5);
        chk("t3.late", done_c - start_c, FLEN - 1 + 3);

        // Reset during the 4th bit, then a clean 8'h3C
        load_one(8'h5A);
        repeat (3) tick();
        rst_n = 1'b0;
        lv = 1'b1; din = 8'hC3;
        tick();
        chk("t4.sout", 32'(bus0.sout), 32'(IDL0));
        chk("t4.valid", 32'(bus0.sout_valid), 0);
        chk("t4.ready", 32'(bus0.load_ready), 0);
        chk("t4.done", 32'(bus1.frame_done), 0);
        lv = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t4.dropped_load", 32'(bus0.busy), 0);
        clear();
        load_one(8'h3C);
        repeat (FLEN + 3) tick();
        chk("t4.nbits", ncap, FLEN);
        chk("t4.lsb", 32'(cap0[7:0]), 32'h3C);
        chk("t4.msb", 32'(cap1[7:0]), 32'h3C);

`ifdef IIITB_PISO_PARITY_EN
        clear();
        load_one(8'h07);
        repeat (FLEN + 2) tick();
        chk("par.07", 32'(cap0[8:0]), 32'h107);
        clear();
        load_one(8'h03);
        repeat (FLEN + 2) tick();
        chk("par.03", 32'(cap0[8:0]), 32'h003);
`endif

        // Randomised traffic with stalls, gaps and occasional resets
        for (int n = 0; n < 3000; n++) begin
            if (!(lv && !acc_last)) begin
                lv  = ($urandom_range(0, 2) != 0);
                din = W'($urandom);
            end
            se    = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            if (ncap >= 60) clear();
            tick();
        end
        rst_n = 1'b1; lv = 1'b0; se = 1'b1;
        repeat (FLEN + 2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
